// File: rtl/systolic_collector.sv
// ============================================================================
// Module   : systolic_collector
// Purpose  : De-skews the column outputs of a 4x4 systolic array into a 4x4
//            result matrix and streams it out row by row with valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_collector #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] c_in0,
    input  logic [DATA_WIDTH-1:0] c_in1,
    input  logic [DATA_WIDTH-1:0] c_in2,
    input  logic [DATA_WIDTH-1:0] c_in3,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [1:0]            out_row,
    output logic [DATA_WIDTH-1:0] out_c0,
    output logic [DATA_WIDTH-1:0] out_c1,
    output logic [DATA_WIDTH-1:0] out_c2,
    output logic [DATA_WIDTH-1:0] out_c3,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [2:0] c_LAST_BEAT = 3'd6;
    localparam logic [1:0] c_LAST_ROW  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                r_state;
    logic [2:0]            r_beat;
    logic [1:0]            r_row;
    logic                  r_done;
    logic                  r_overrun;
    logic [DATA_WIDTH-1:0] r_c [4][4];

    logic [DATA_WIDTH-1:0] w_cin [4];
    logic                  w_capture;
    logic                  w_out_valid;

    assign w_cin[0]    = c_in0;
    assign w_cin[1]    = c_in1;
    assign w_cin[2]    = c_in2;
    assign w_cin[3]    = c_in3;
    assign w_capture   = (r_state == S_COLLECT) && in_valid;
    assign w_out_valid = (r_state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_beat    <= 3'd0;
            r_row     <= 2'd0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_COLLECT;
                        r_beat    <= 3'd0;
                        r_done    <= 1'b0;
                        // A beat arriving alongside the arm pulse is still lost
                        r_overrun <= in_valid;
                    end else if (in_valid) begin
                        r_overrun <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (in_valid) begin
                        if (r_beat == c_LAST_BEAT) begin
                            r_state <= S_DRAIN;
                            r_beat  <= 3'd0;
                            r_row   <= 2'd0;
                        end else begin
                            r_beat <= r_beat + 3'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (in_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (out_ready) begin
                        if (r_row == c_LAST_ROW) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_row   <= 2'd0;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Column j of beat k belongs to row k-j; edge beats carry unused lanes
    always_ff @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                if (!rst_n) begin
                    r_c[r][j] <= '0;
                end else if (w_capture && (r_beat == 3'(r + j))) begin
                    r_c[r][j] <= w_cin[j];
                end
            end
        end
    end

    assign out_valid = w_out_valid;
    assign out_row   = w_out_valid ? r_row : 2'd0;
    assign out_c0    = w_out_valid ? r_c[r_row][0] : '0;
    assign out_c1    = w_out_valid ? r_c[r_row][1] : '0;
    assign out_c2    = w_out_valid ? r_c[r_row][2] : '0;
    assign out_c3    = w_out_valid ? r_c[r_row][3] : '0;
    assign busy      = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_systolic_collector.sv
// ============================================================================
// Module   : tb_systolic_collector
// Purpose  : Directed self-checking bench for systolic_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] c_in0 = '0, c_in1 = '0, c_in2 = '0, c_in3 = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [1:0]  out_row;
    logic [31:0] out_c0, out_c1, out_c2, out_c3;
    logic        busy, done, overrun;

    int errors = 0;
    int checks = 0;

    systolic_collector #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .c_in0(c_in0), .c_in1(c_in1), .c_in2(c_in2), .c_in3(c_in3),
        .out_ready(out_ready), .out_valid(out_valid), .out_row(out_row),
        .out_c0(out_c0), .out_c1(out_c1), .out_c2(out_c2), .out_c3(out_c3),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] row_exp(input logic [31:0] base, input int r);
        return {base + 32'(16*r + 1), base + 32'(16*r + 2),
                base + 32'(16*r + 3), base + 32'(16*r + 4)};
    endfunction

    // Drive beat k of matrix C[r][j] = base + 0x10*r + j + 1; unused lanes get junk
    task automatic set_beat(input int k, input logic [31:0] base);
        logic [31:0] v [4];
        for (int j = 0; j < 4; j++) begin
            int r;
            r = k - j;
            if (r >= 0 && r <= 3) v[j] = base + 32'(16*r + j + 1);
            else                  v[j] = 32'hBAD0_0000 + 32'(k*16 + j);
        end
        c_in0 = v[0]; c_in1 = v[1]; c_in2 = v[2]; c_in3 = v[3];
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({out_valid, busy, done, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {out_valid, busy, done, overrun});
        end
        checks++;
        if ({out_row, out_c0, out_c1, out_c2, out_c3} !== 130'd0) begin
            errors++;
            $display("FAIL reset_data: got row=%0d c0=%h want all zero", out_row, out_c0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL basic_arm: busy,done=%b want 10", {busy, done});
        end
        for (int k = 0; k < 7; k++) begin
            set_beat(k, 32'h0); tick();
            if (k < 6) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_early_valid: beat %0d out_valid=%b want 0", k, out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: out_valid=%b want 1", out_valid);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_row !== 2'(r) || {out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h0, r)) begin
                errors++;
                $display("FAIL basic_row%0d: got row=%0d %h %h %h %h want %h", r, out_row,
                         out_c0, out_c1, out_c2, out_c3, row_exp(32'h0, r));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, done} !== 3'b001 || out_c0 !== 32'h0 || out_row !== 2'd0) begin
            errors++;
            $display("FAIL basic_done: valid,busy,done=%b c0=%h want 001 and 0",
                     {out_valid, busy, done}, out_c0);
        end
    endtask

    task automatic test_gap_backpressure();
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL gap_done_clear: done=%b want 0", done);
        end
        for (int k = 0; k < 3; k++) begin set_beat(k, 32'h0); tick(); end
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++;
        if ({out_valid, busy} !== 2'b01) begin
            errors++;
            $display("FAIL gap_hold: valid,busy=%b want 01", {out_valid, busy});
        end
        for (int k = 3; k < 7; k++) begin set_beat(k, 32'h0); tick(); end
        in_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
            tick();
            checks++;
            if (out_row !== 2'd1 || {out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h0, 1)) begin
                errors++;
                $display("FAIL gap_stall: got row=%0d c0=%h want row 1 c0=%h", out_row, out_c0,
                         32'h11);
            end
        end
        out_ready = 1'b1;
        for (int r = 1; r < 4; r++) begin
            checks++;
            if (out_row !== 2'(r) || done !== 1'b0 ||
                {out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h0, r)) begin
                errors++;
                $display("FAIL gap_row%0d: got row=%0d done=%b c0=%h want c0=%h", r, out_row,
                         done, out_c0, 32'(16*r + 1));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL gap_done: valid,busy,done=%b want 001", {out_valid, busy, done});
        end
    endtask

    task automatic test_start_ignored();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_beat(k, 32'h200);
            start = (k == 3);
            tick();
            start = 1'b0;
            if (k == 5) begin
                checks++;
                if ({out_valid, busy} !== 2'b01) begin
                    errors++;
                    $display("FAIL ign_collect: valid,busy=%b want 01 after 6 beats",
                             {out_valid, busy});
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            start = (r == 2);
            checks++;
            if (out_row !== 2'(r) || done !== 1'b0 ||
                {out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h200, r)) begin
                errors++;
                $display("FAIL ign_row%0d: got row=%0d c0=%h want c0=%h", r, out_row, out_c0,
                         32'h200 + 32'(16*r + 1));
            end
            tick();
        end
        start = 1'b0; out_ready = 1'b0;
        checks++;
        if ({busy, done} !== 2'b01) begin
            errors++;
            $display("FAIL ign_done: busy,done=%b want 01", {busy, done});
        end
    endtask

    task automatic test_overrun();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        set_beat(0, 32'hFFFF_FF00); tick(); in_valid = 1'b0; tick();
        checks++;
        if ({overrun, busy} !== 2'b10) begin
            errors++;
            $display("FAIL ovr_idle: overrun,busy=%b want 10", {overrun, busy});
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({overrun, busy} !== 2'b01) begin
            errors++;
            $display("FAIL ovr_clear: overrun,busy=%b want 01", {overrun, busy});
        end
        for (int k = 0; k < 7; k++) begin set_beat(k, 32'h0); tick(); end
        set_beat(2, 32'hEEEE_0000); out_ready = 1'b0; tick(); in_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1 || {out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h0, 0)) begin
            errors++;
            $display("FAIL ovr_drain: overrun=%b c0=%h want 1 and %h", overrun, out_c0, 32'h1);
        end
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if ({out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h0, r)) begin
                errors++;
                $display("FAIL ovr_row%0d: got %h %h %h %h want %h", r, out_c0, out_c1,
                         out_c2, out_c3, row_exp(32'h0, r));
            end
            tick();
        end
        out_ready = 1'b0;
        // Arm and stray beat on the same edge: beat lost, overrun wins
        start = 1'b1; set_beat(0, 32'hDDDD_0000); tick(); start = 1'b0; in_valid = 1'b0;
        checks++;
        if ({overrun, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL ovr_same_cycle: overrun,busy,done=%b want 110", {overrun, busy, done});
        end
        for (int k = 0; k < 7; k++) begin
            set_beat(k, 32'h400); tick();
            if (k == 5) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_dropped_beat: out_valid=%b want 0 after 6 beats", out_valid);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if ({out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h400, r)) begin
                errors++;
                $display("FAIL ovr2_row%0d: got c0=%h want %h", r, out_c0, 32'h400 + 32'(16*r + 1));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        checks++;
        if ({done, overrun} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_pre: done,overrun=%b want 11", {done, overrun});
        end
        start = 1'b1; tick(); start = 1'b0;
        checks++;
        if ({done, overrun, busy} !== 3'b001) begin
            errors++;
            $display("FAIL b2b_arm: done,overrun,busy=%b want 001", {done, overrun, busy});
        end
        for (int k = 0; k < 7; k++) begin set_beat(k, 32'h100); tick(); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if (out_row !== 2'(r) || {out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h100, r)) begin
                errors++;
                $display("FAIL b2b_row%0d: got row=%0d c0=%h want %h", r, out_row, out_c0,
                         32'h100 + 32'(16*r + 1));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_done: done,busy=%b want 10", {done, busy});
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) begin set_beat(k, 32'h500); tick(); end
        rst_n = 1'b0; out_ready = 1'b1; tick();
        in_valid = 1'b0; rst_n = 1'b1; out_ready = 1'b0;
        checks++;
        if ({out_valid, busy, done, overrun, out_row} !== 6'd0 || out_c0 !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: valid,busy,done,ovr=%b c0=%h want zeros",
                     {out_valid, busy, done, overrun}, out_c0);
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            set_beat(k, 32'h300); tick();
            if (k == 1) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rstmid_residue_beat: out_valid=%b want 0", out_valid);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            checks++;
            if ({out_c0, out_c1, out_c2, out_c3} !== row_exp(32'h300, r)) begin
                errors++;
                $display("FAIL rstmid_row%0d: got c0=%h want %h", r, out_c0, 32'h300 + 32'(16*r + 1));
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_done: done=%b want 1", done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap_backpressure();
        test_start_ignored();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
